// File: rtl/slice_scheduler.sv
// slice_scheduler: measures the hall-sensor rotation period and splits each
// turn into 2**SLICE_BITS equal slices, raising a held position_sync request
// to the driver controller on every slice boundary.
//
// state   | meaning
// NO_ROT  | no rotation known; any hall event starts a measurement
// MEASURE | timing the first full turn, no syncs yet
// RUN     | period known; slice boundaries and syncs are generated
module slice_scheduler #(
  parameter int SLICE_BITS = 8,
  parameter int CNT_W      = 24,
  parameter int MIN_PERIOD = 1000,
  parameter int MAX_PERIOD = 2**24-1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  clk_enable,
  input  logic                  hall_n,
  output logic                  position_sync,
  output logic [SLICE_BITS-1:0] slice_index,
  output logic                  rotation_valid,
  output logic [CNT_W-1:0]      period,
  output logic [7:0]            overrun_count
);

  typedef enum logic [1:0] {NO_ROT, MEASURE, RUN} state_t;

  localparam logic [CNT_W-1:0]      MIN_M1 = CNT_W'(MIN_PERIOD - 1);
  localparam logic [CNT_W-1:0]      MAX_P  = CNT_W'(MAX_PERIOD);
  localparam logic [SLICE_BITS-1:0] LAST   = '1;

  state_t                state, state_nxt;
  logic                  hall_s1, hall_s2, hall_s3, hall_evt;
  logic [CNT_W-1:0]      rot_cnt, period_r, timer;
  logic [SLICE_BITS-1:0] slice_r;
  logic                  pend;
  logic [7:0]            ovr;
  logic                  accept, at_max, load_turn, drop, tick, raise;
  logic [CNT_W-1:0]      new_period;

  // slice length for a given period; never zero so short turns still advance
  function automatic logic [CNT_W-1:0] slice_len(input logic [CNT_W-1:0] p);
    logic [CNT_W-1:0] s;
    s = p >> SLICE_BITS;
    return (s == '0) ? CNT_W'(1) : s;
  endfunction

  assign at_max     = (rot_cnt == MAX_P);
  assign accept     = hall_evt && ((state == NO_ROT) || (rot_cnt >= MIN_M1));
  assign new_period = rot_cnt + CNT_W'(1);
  assign raise      = load_turn | tick;

  // hall synchronizer and falling-edge pulse (idle level is high)
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hall_s1  <= 1'b1;
      hall_s2  <= 1'b1;
      hall_s3  <= 1'b1;
      hall_evt <= 1'b0;
    end else begin
      hall_s1  <= hall_n;
      hall_s2  <= hall_s1;
      hall_s3  <= hall_s2;
      hall_evt <= hall_s3 & ~hall_s2;
    end
  end

  // state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= NO_ROT;
    else       state <= state_nxt;
  end

  // next-state logic; a hall event beats a timeout in the same cycle
  always_comb begin
    state_nxt = state;
    case (state)
      NO_ROT:  if (accept) state_nxt = MEASURE;
      MEASURE: if (accept) state_nxt = RUN;
               else if (at_max) state_nxt = NO_ROT;
      RUN:     if (!accept && at_max) state_nxt = NO_ROT;
      default: state_nxt = NO_ROT;
    endcase
  end

  // per-state control decode
  always_comb begin
    rotation_valid = 1'b0;
    load_turn      = 1'b0;
    drop           = 1'b0;
    tick           = 1'b0;
    case (state)
      MEASURE: load_turn = accept;
      RUN: begin
        rotation_valid = 1'b1;
        load_turn      = accept;
        drop           = !accept && at_max;
        tick           = !accept && !at_max && (slice_r != LAST) && (timer == '0);
      end
      default: ;
    endcase
  end

  // free-running period counter, saturating so a stalled rotor is detectable
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)        rot_cnt <= '0;
    else if (accept)  rot_cnt <= '0;
    else if (!at_max) rot_cnt <= rot_cnt + CNT_W'(1);
  end

  // period latch and slice index
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      period_r <= '0;
      slice_r  <= '0;
    end else begin
      if (load_turn) period_r <= new_period;
      if (load_turn || drop) slice_r <= '0;
      else if (tick)         slice_r <= slice_r + SLICE_BITS'(1);
    end
  end

  // slice down-counter; boundary at zero, frozen on the last slice
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)          timer <= '0;
    else if (load_turn) timer <= slice_len(new_period) - CNT_W'(1);
    else if (drop)      timer <= '0;
    else if (tick)      timer <= slice_len(period_r) - CNT_W'(1);
    else if ((state == RUN) && (slice_r != LAST) && (timer != '0))
      timer <= timer - CNT_W'(1);
  end

  // sync request held until a clk_enable cycle; merged requests are counted
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pend <= 1'b0;
      ovr  <= '0;
    end else if (drop) begin
      pend <= 1'b0;
    end else begin
      pend <= raise | (pend & ~clk_enable);
      if (raise && pend && !clk_enable && (ovr != 8'hFF)) ovr <= ovr + 8'd1;
    end
  end

  assign position_sync = pend;
  assign slice_index   = slice_r;
  assign period        = period_r;
  assign overrun_count = ovr;

endmodule

// File: tb/tb_slice_scheduler.sv
// tb_slice_scheduler: randomized hall/clk_enable stimulus against a
// time-based reference model of the slice scheduler.
module tb_slice_scheduler;

  localparam int SB   = 4;
  localparam int N    = 2**SB;
  localparam int CW   = 16;
  localparam int MINP = 20;
  localparam int MAXP = 4095;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          clk_enable = 1'b0;
  logic          hall_n = 1'b1;
  logic          position_sync;
  logic [SB-1:0] slice_index;
  logic          rotation_valid;
  logic [CW-1:0] period;
  logic [7:0]    overrun_count;

  slice_scheduler #(.SLICE_BITS(SB), .CNT_W(CW), .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP)) dut (
    .clk(clk), .nrst(nrst), .clk_enable(clk_enable), .hall_n(hall_n),
    .position_sync(position_sync), .slice_index(slice_index),
    .rotation_valid(rotation_valid), .period(period), .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // reference model: phase 0/1/2 = no rotation / measuring / running
  int cyc = 0;
  int phase, t_last, m_period, m_slice, m_pend, m_ovr;
  int evq[$];
  bit prev_h;
  int low_left = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    phase = 0; t_last = cyc; m_period = 0; m_slice = 0; m_pend = 0; m_ovr = 0;
    evq.delete(); prev_h = 1'b1;
  endtask

  // one posedge; cyc is the number of that edge
  task automatic model_step(input bit h, input bit en);
    bit ev, acc, raise, drop;
    int el, d, iv;
    if (prev_h && !h) evq.push_back(cyc + 3);
    prev_h = h;
    ev = 1'b0;
    if (evq.size() > 0 && evq[0] == cyc) begin ev = 1'b1; void'(evq.pop_front()); end
    el = cyc - t_last - 1;
    if (el > MAXP) el = MAXP;
    acc = ev && (phase == 0 || el >= MINP - 1);
    raise = 1'b0; drop = 1'b0;
    if (acc) begin
      if (phase > 0) begin m_period = el + 1; m_slice = 0; raise = 1'b1; end
      phase = (phase == 0) ? 1 : 2;
      t_last = cyc;
    end else if (phase > 0 && el == MAXP) begin
      if (phase == 2) begin m_slice = 0; drop = 1'b1; end
      phase = 0;
    end else if (phase == 2) begin
      d  = cyc - t_last;
      iv = m_period / N;
      if (iv == 0) iv = 1;
      if (d % iv == 0 && d / iv >= 1 && d / iv <= N - 1) begin
        m_slice = d / iv; raise = 1'b1;
      end
    end
    if (drop) m_pend = 0;
    else begin
      if (raise && m_pend != 0 && !en && m_ovr < 255) m_ovr++;
      m_pend = (raise || (m_pend != 0 && !en)) ? 1 : 0;
    end
  endtask

  task automatic check_all(input string pfx);
    chk({pfx, "sync"},   32'(position_sync),  32'(m_pend));
    chk({pfx, "slice"},  32'(slice_index),    32'(m_slice));
    chk({pfx, "valid"},  32'(rotation_valid), 32'(phase == 2));
    chk({pfx, "period"}, 32'(period),         32'(m_period));
    chk({pfx, "ovr"},    32'(overrun_count),  32'(m_ovr));
  endtask

  task automatic tick(input bit fall, input bit en);
    bit h;
    @(negedge clk);
    check_all("");
    if (fall) low_left = 2;
    h = (low_left > 0) ? 1'b0 : 1'b1;
    if (low_left > 0) low_left--;
    hall_n = h;
    clk_enable = en;
    @(posedge clk);
    cyc++;
    model_step(h, en);
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    hall_n = 1'b1;
    low_left = 0;
    #1;
    model_reset();
    chk("rst_sync", 32'(position_sync), 32'd0);
    chk("rst_slice", 32'(slice_index), 32'd0);
    chk("rst_valid", 32'(rotation_valid), 32'd0);
    chk("rst_period", 32'(period), 32'd0);
    chk("rst_ovr", 32'(overrun_count), 32'd0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    model_reset();
    @(posedge clk);
    cyc++;
    model_step(1'b1, clk_enable);
  endtask

  // mode: 0 always on, 1 one in four, 2 off, 3 coin flip, 4 off on ticks 5..7
  function automatic bit en_for(input int mode, input int i);
    case (mode)
      0:       return 1'b1;
      1:       return ($urandom_range(0, 3) == 0);
      2:       return 1'b0;
      3:       return ($urandom_range(0, 1) == 1);
      default: return !(i >= 5 && i <= 7);
    endcase
  endfunction

  task automatic run_turn(input int len, input int mode, input int glitch_at);
    for (int i = 0; i < len; i++) tick(i == 0 || i == glitch_at, en_for(mode, i));
  endtask

  task automatic idle(input int n, input int mode);
    for (int i = 0; i < n; i++) tick(1'b0, en_for(mode, i));
  endtask

  initial begin
    do_reset();
    idle(10, 0);
    // steady rotation, interval 20
    repeat (4) run_turn(320, 0, -1);
    // sparse clk_enable
    repeat (3) run_turn(320, 1, -1);
    // faster turn cuts slices short, slower turn stretches the last slice
    run_turn(200, 0, -1);
    run_turn(200, 0, -1);
    run_turn(480, 0, -1);
    run_turn(480, 1, -1);
    // glitches inside MIN_PERIOD, then an edge one cycle short of / exactly at the limit
    run_turn(320, 0, 10);
    run_turn(320, 0, 16);
    run_turn(19, 0, -1);
    run_turn(301, 0, -1);
    run_turn(20, 0, -1);
    run_turn(320, 0, -1);
    // stall: timeout, then two edges to resume
    idle(4200, 3);
    run_turn(300, 0, -1);
    run_turn(300, 0, -1);
    run_turn(300, 1, -1);
    // interval of one with clk_enable withheld, then overrun saturation
    run_turn(24, 0, -1);
    run_turn(24, 0, -1);
    run_turn(24, 4, -1);
    repeat (20) run_turn(24, 2, -1);
    run_turn(24, 0, -1);
    // reset mid-run
    run_turn(150, 0, -1);
    do_reset();
    run_turn(320, 0, -1);
    run_turn(320, 0, -1);
    run_turn(320, 0, -1);
    // randomized turns
    for (int k = 0; k < 60; k++) begin
      int len, mode, gl;
      len  = $urandom_range(20, 700);
      mode = $urandom_range(0, 3);
      gl   = ($urandom_range(0, 4) == 0) ? $urandom_range(3, len - 3) : -1;
      run_turn(len, mode, gl);
      if (k == 30) idle(4200, 0);
      if (k == 45) begin run_turn(80, 0, -1); do_reset(); end
    end
    idle(50, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
